// File: rtl/dm_resp.sv
// dm_resp: word-addressed data memory with a req/ready handshake and WAIT programmable wait states.
module dm_resp #(
   parameter int ADDR_W = 10,
   parameter int WAIT   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [3:0]        be,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              accept, commit;
   logic [31:0]       mem [0:(1<<ADDR_W)-1];

   always_comb begin
      accept  = state_q == IDLE && req;
      commit  = state_q == BUSY && cnt_q == 4'd0;
      state_d = accept ? BUSY : commit ? RESP : state_q == RESP ? IDLE : state_q;
      cnt_d   = accept ? 4'(WAIT) : (state_q == BUSY && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      we_d    = accept ? we : we_q;
      addr_d  = accept ? addr : addr_q;
      be_d    = accept ? be : be_q;
      wdata_d = accept ? wdata : wdata_q;
      // all-zero byte enables flag an error and leave both memory and rdata untouched
      rdata_d = (commit && !we_q && be_q != 4'd0) ? mem[addr_q] : rdata_q;
      ready_d = commit;
      err_d   = commit && be_q == 4'd0;
      busy_d  = state_d != IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   // commit depends on state_q, which reset forces to IDLE, so a reset before the commit edge blocks the write
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (commit && we_q && be_q[i]) mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
   end

   assign rdata = rdata_q;
   assign ready = ready_q;
   assign busy  = busy_q;
   assign err   = err_q;
endmodule

// File: tb/tb_dm_resp.sv
// tb_dm_resp: directed checks of dm_resp with WAIT=2 and WAIT=0 instances.
module tb_dm_resp;
   logic        clk = 1'b0;
   logic        rst, req, req0, we;
   logic [9:0]  addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata, rdata0;
   logic        ready, busy, err, ready0, busy0, err0;
   int          ncmp = 0, nfail = 0;

   always #5 clk = ~clk;

   dm_resp #(.ADDR_W(10), .WAIT(2)) u2 (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .be(be), .wdata(wdata),
      .rdata(rdata), .ready(ready), .busy(busy), .err(err));

   dm_resp #(.ADDR_W(10), .WAIT(0)) u0 (
      .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .be(be), .wdata(wdata),
      .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one transaction on the WAIT=2 instance; inputs are scrambled while busy
   task automatic txn(input logic w, input logic [9:0] a, input logic [3:0] b, input logic [31:0] d,
                      input logic exp_err, input logic [31:0] exp_rd, input string tag);
      int n, nb;
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      step();
      req = 1'b0; we = ~w; addr = ~a; be = ~b; wdata = ~d;
      n = 0;
      nb = 0;
      forever begin
         nb += int'(busy);
         if (ready || n == 20) break;
         step();
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'd3);
      chk({tag, "_busy"}, 32'(nb), 32'd4);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      chk({tag, "_rdata"}, rdata, exp_rd);
      step();
      chk({tag, "_after"}, {29'd0, ready, busy, err}, 32'd0);
   endtask

   initial begin
      logic [4:0] pat;
      int pulses;
      rst = 1'b0; req = 1'b0; req0 = 1'b0; we = 1'b0; addr = '0; be = 4'd0; wdata = 32'd0;
      #1;
      chk("rst_flags", {28'd0, ready, busy, err, ready0}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      step();
      step();
      rst = 1'b1;
      txn(1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, "wr5");
      txn(1'b0, 10'd5, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, "rd5");
      txn(1'b1, 10'd7, 4'hF, 32'h11223344, 1'b0, 32'hDEADBEEF, "wr7");
      txn(1'b1, 10'd7, 4'b0101, 32'hAABBCCDD, 1'b0, 32'hDEADBEEF, "wr7p");
      txn(1'b0, 10'd7, 4'hF, 32'h0, 1'b0, 32'h11BB33DD, "rd7");
      txn(1'b1, 10'd3, 4'hF, 32'hCAFEF00D, 1'b0, 32'h11BB33DD, "wr3");
      txn(1'b0, 10'd5, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, "rd5b");
      txn(1'b1, 10'd3, 4'h0, 32'h12345678, 1'b1, 32'hDEADBEEF, "wr3e");
      txn(1'b0, 10'd3, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF, "rd3e");
      txn(1'b0, 10'd3, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D, "rd3");
      txn(1'b1, 10'd1023, 4'hF, 32'h0BADF00D, 1'b0, 32'hCAFEF00D, "wr1023");
      txn(1'b0, 10'd1023, 4'hF, 32'h0, 1'b0, 32'h0BADF00D, "rd1023");
      // reset one cycle into a write; memory must keep DEADBEEF
      req = 1'b1; we = 1'b1; addr = 10'd5; be = 4'hF; wdata = 32'h55555555;
      step();
      req = 1'b0;
      step();
      #2 rst = 1'b0;
      #1;
      chk("midrst_flags", {29'd0, ready, busy, err}, 32'd0);
      chk("midrst_rdata", rdata, 32'd0);
      step();
      step();
      rst = 1'b1;
      txn(1'b0, 10'd5, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, "rd5_post_rst");
      txn(1'b0, 10'd7, 4'b1000, 32'h0, 1'b0, 32'h11BB33DD, "rd7_be_nomask");
      // WAIT=0 with req held: ready pattern after E0..E4
      req0 = 1'b1; we = 1'b1; addr = 10'd9; be = 4'hF; wdata = 32'h0F0F0F0F;
      pat = 5'b10010;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         pulses += int'(ready0);
         chk($sformatf("w0_ready_%0d", i), {31'd0, ready0}, {31'd0, pat[i]});
      end
      req0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         pulses += int'(ready0);
      end
      chk("w0_pulses", 32'(pulses), 32'd2);
      req0 = 1'b1; we = 1'b0;
      step();
      req0 = 1'b0;
      step();
      chk("w0_rd_ready", {30'd0, ready0, err0}, 32'd2);
      chk("w0_rd_data", rdata0, 32'h0F0F0F0F);
      step();
      chk("w0_idle", {30'd0, ready0, busy0}, 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
